sdram_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller top between the CPU data port (master 0) and the instruction-fetch port (master 1). It holds a grant for the whole transaction and inserts a one-cycle release gap after every ack so the slave sees a fresh `stb & cyc` rising edge per access. A watchdog aborts hung transactions with an error to the requester.

---
 rtl/sdram_wb_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wb_arbiter
// Purpose  : Two-master Wishbone arbiter for the single slave port of the
//            SDRAM controller. Master 0 is the CPU data port and master 1 is
//            the instruction-fetch port. A grant is held for one whole
//            transaction. Every transaction is followed by a one-cycle
//            release gap, so the slave sees a fresh cyc/stb rising edge for
//            each access. A watchdog aborts a hung access and returns an
//            error to the requester.
// Ports    : wb_clk_i, rst_n (async, active low)
//            m0_* / m1_*  master-side Wishbone (cyc, stb, we, addr, data, sel
//                         in; data, ack, err out)
//            s_*          slave-side Wishbone (cyc, stb, we, addr, data, sel
//                         out; data, ack in)
//            grant_o      one-hot current grant (bit0 = m0), for debug
// Config   : SDRAM_ARB_RR_EN defined   -> round-robin on a tie
//            SDRAM_ARB_RR_EN undefined -> fixed priority, m0 wins a tie
// Revision : 1.0 - initial release
// ============================================================================
module sdram_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    // master 0 (CPU data)
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1 (instruction fetch)
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // SDRAM slave
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    // debug
    output logic [1:0]  grant_o
);

    localparam int                c_WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_ONE = c_WD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT0    = 2'd1,
        ST_GNT1    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last;      // index of the master granted most recently
    logic [c_WD_W-1:0]   r_wdog;
    logic [31:0]         r_m0_data;   // last value presented on m0_data_o
    logic [31:0]         r_m1_data;   // last value presented on m1_data_o

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_tout;
    logic w_tie_win;
    logic w_win;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;
    assign w_gnt0 = (r_state == ST_GNT0);
    assign w_gnt1 = (r_state == ST_GNT1);
    assign w_tout = (r_wdog == c_WD_MAX);

`ifdef SDRAM_ARB_RR_EN
    // Round-robin: the master that was not served last wins a tie.
    assign w_tie_win = ~r_last;
`else
    // Fixed priority: m0 always wins a tie; r_last is tracked but ignored.
    assign w_tie_win = 1'b0 & r_last;
`endif

    // Winner index (0 = m0, 1 = m1) when at least one master requests.
    assign w_win = (w_req0 & w_req1) ? w_tie_win : w_req1;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_wdog    <= '0;
            r_m0_data <= '0;
            r_m1_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_state <= w_win ? ST_GNT1 : ST_GNT0;
                        r_last  <= w_win;
                        r_wdog  <= '0;
                    end
                end
                ST_GNT0: begin
                    r_m0_data <= s_data_i;
                    // Ack, abandoned cycle and timeout all end the grant.
                    // The counter only advances below its limit, so it
                    // saturates rather than wrapping.
                    if (s_ack_i | ~m0_cyc_i | w_tout) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_wdog <= r_wdog + c_WD_ONE;
                    end
                end
                ST_GNT1: begin
                    r_m1_data <= s_data_i;
                    if (s_ack_i | ~m1_cyc_i | w_tout) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_wdog <= r_wdog + c_WD_ONE;
                    end
                end
                ST_RELEASE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Response paths are combinational so a slave ack reaches the master in
    // the same cycle. Everything decodes from r_state, so an async reset
    // drops the slave strobe immediately.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        m0_data_o = r_m0_data;
        m1_data_o = r_m1_data;
        if (w_gnt0) begin
            s_cyc_o   = w_req0;
            s_stb_o   = w_req0;
            s_we_o    = m0_we_i;
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            s_sel_o   = m0_sel_i;
            m0_ack_o  = s_ack_i;
            m0_data_o = s_data_i;
            // A same-cycle ack wins over the timeout error.
            m0_err_o  = w_tout & m0_cyc_i & ~s_ack_i;
        end else if (w_gnt1) begin
            s_cyc_o   = w_req1;
            s_stb_o   = w_req1;
            s_we_o    = m1_we_i;
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            s_sel_o   = m1_sel_i;
            m1_ack_o  = s_ack_i;
            m1_data_o = s_data_i;
            m1_err_o  = w_tout & m1_cyc_i & ~s_ack_i;
        end
    end

    assign grant_o = {w_gnt1, w_gnt0};

endmodule
`default_nettype wire

// File: tb/tb_sdram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_wb_arbiter
// Purpose  : Self-checking bench for sdram_wb_arbiter. A transaction-level
//            model tracks who owns the slave, how long the owner has waited,
//            and the release gap; a compare process checks every DUT output
//            against it on each falling edge. Directed scenarios add literal
//            expectations for latencies, arbitration order and data values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_wb_arbiter;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_addr = 0, m0_wdat = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_rdat;
    logic        m0_ack, m0_err;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_addr = 0, m1_wdat = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_rdat;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_wdat;
    logic [3:0]  s_sel;
    logic [31:0] s_rdat = 0;
    logic        s_ack = 0;
    logic [1:0]  grant;

    sdram_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i (clk),      .rst_n    (rst_n),
        .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),  .m0_we_i (m0_we),
        .m0_addr_i(m0_addr),  .m0_data_i(m0_wdat), .m0_sel_i(m0_sel),
        .m0_data_o(m0_rdat),  .m0_ack_o (m0_ack),  .m0_err_o(m0_err),
        .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),  .m1_we_i (m1_we),
        .m1_addr_i(m1_addr),  .m1_data_i(m1_wdat), .m1_sel_i(m1_sel),
        .m1_data_o(m1_rdat),  .m1_ack_o (m1_ack),  .m1_err_o(m1_err),
        .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),   .s_we_o  (s_we),
        .s_addr_o (s_addr),   .s_data_o (s_wdat),  .s_sel_o (s_sel),
        .s_data_i (s_rdat),   .s_ack_i  (s_ack),
        .grant_o  (grant)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          mo_own  = -1;    // current owner of the slave, -1 = none
    bit          mo_rel  = 0;     // in the one-cycle gap after a transaction
    int          mo_age  = 0;     // cycles the current owner has been granted
    int          mo_last = 1;     // most recently granted master
    logic [31:0] mo_hold [2] = '{32'h0, 32'h0};

    function automatic bit cyc_of(input int m);
        return (m == 0) ? m0_cyc : m1_cyc;
    endfunction

    function automatic bit req_of(input int m);
        return (m == 0) ? (m0_cyc & m0_stb) : (m1_cyc & m1_stb);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int win;
        if (!rst_n) begin
            mo_own = -1; mo_rel = 0; mo_age = 0; mo_last = 1;
            mo_hold[0] = 0; mo_hold[1] = 0;
        end else if (mo_own >= 0) begin
            mo_hold[mo_own] = s_rdat;
            if (s_ack || !cyc_of(mo_own) || mo_age >= T) begin
                mo_own = -1;
                mo_rel = 1;
            end else begin
                mo_age++;
            end
        end else if (mo_rel) begin
            mo_rel = 0;
        end else if (req_of(0) || req_of(1)) begin
            if (req_of(0) && req_of(1)) begin
`ifdef SDRAM_ARB_RR_EN
                win = (mo_last == 0) ? 1 : 0;
`else
                win = 0;
`endif
            end else begin
                win = req_of(1) ? 1 : 0;
            end
            mo_own  = win;
            mo_age  = 0;
            mo_last = win;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic        e_cyc, e_we, e_ack0, e_ack1, e_err0, e_err1;
        logic [31:0] e_addr, e_wdat, e_d0, e_d1;
        logic [3:0]  e_sel;
        logic [1:0]  e_gnt;
        e_cyc = 0; e_we = 0; e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
        e_addr = 0; e_wdat = 0; e_sel = 0; e_gnt = 0;
        e_d0 = mo_hold[0]; e_d1 = mo_hold[1];
        if (mo_own == 0) begin
            e_cyc = m0_cyc & m0_stb; e_we = m0_we; e_addr = m0_addr;
            e_wdat = m0_wdat; e_sel = m0_sel; e_ack0 = s_ack; e_d0 = s_rdat;
            e_err0 = !s_ack && m0_cyc && (mo_age >= T); e_gnt = 2'b01;
        end else if (mo_own == 1) begin
            e_cyc = m1_cyc & m1_stb; e_we = m1_we; e_addr = m1_addr;
            e_wdat = m1_wdat; e_sel = m1_sel; e_ack1 = s_ack; e_d1 = s_rdat;
            e_err1 = !s_ack && m1_cyc && (mo_age >= T); e_gnt = 2'b10;
        end
        chk("cmp s_cyc", s_cyc, e_cyc);
        chk("cmp s_stb", s_stb, e_cyc);
        chk("cmp s_we", s_we, e_we);
        chk("cmp s_addr", s_addr, e_addr);
        chk("cmp s_data", s_wdat, e_wdat);
        chk("cmp s_sel", s_sel, e_sel);
        chk("cmp m0_ack", m0_ack, e_ack0);
        chk("cmp m1_ack", m1_ack, e_ack1);
        chk("cmp m0_err", m0_err, e_err0);
        chk("cmp m1_err", m1_err, e_err1);
        chk("cmp m0_data", m0_rdat, e_d0);
        chk("cmp m1_data", m1_rdat, e_d1);
        chk("cmp grant", grant, e_gnt);
    end

    int cyc_cnt = 0;
    int ack0_n  = 0;
    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) if (m0_ack === 1'b1) ack0_n++;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input int m, input bit c, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0_cyc = c; m0_stb = c; m0_we = we; m0_addr = a; m0_wdat = d; m0_sel = s;
        end else begin
            m1_cyc = c; m1_stb = c; m1_we = we; m1_addr = a; m1_wdat = d; m1_sel = s;
        end
    endtask

    // Returns on the falling edge of the first cycle with any grant.
    task automatic wait_any(input int budget, output int win);
        bit ok;
        ok  = 0;
        win = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant != 2'b00) begin
                ok  = 1;
                win = grant[1] ? 1 : 0;
                break;
            end
        end
        chk("grant within budget", ok, 1);
    endtask

    // Slave acks one cycle, then both masters drop their requests.
    task automatic finish_xfer(input logic [31:0] d);
        tick();
        s_ack = 1; s_rdat = d;
        tick();
        s_ack = 0; s_rdat = 0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int win, g, e, a0;
        bit seen;
        int exp_seq [4];
`ifdef SDRAM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset grant", grant, 2'b00);
        chk("reset s_cyc", s_cyc, 0);
        chk("reset s_addr", s_addr, 0);
        chk("reset m0_data", m0_rdat, 0);
        chk("reset m1_ack", m1_ack, 0);
        tick();
        rst_n = 1;
        tick();

        // ---- m0 read of 0x100, slave answers after 5 cycles ----
        a0 = ack0_n;
        set_m(0, 1, 0, 32'h100, 0, 4'hF);
        @(negedge clk);
        chk("stb not same cycle", s_stb, 0);
        @(negedge clk);
        chk("stb one cycle after req", s_stb, 1);
        chk("read addr", s_addr, 32'h100);
        repeat (5) tick();
        s_ack = 1; s_rdat = 32'hDEADBEEF;
        @(negedge clk);
        chk("read ack", m0_ack, 1);
        chk("read data", m0_rdat, 32'hDEADBEEF);
        tick();
        s_ack = 0; s_rdat = 0;
        set_m(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stb low after ack", s_stb, 0);
        chk("read data held", m0_rdat, 32'hDEADBEEF);
        tick();
        chk("ack one cycle", ack0_n - a0, 1);

        // ---- m1 write 0x12345678 sel 0011 to 0x2000 ----
        set_m(1, 1, 1, 32'h2000, 32'h12345678, 4'b0011);
        wait_any(4, win);
        chk("write winner", win, 1);
        for (int i = 0; i < 3; i++) begin
            chk("write we", s_we, 1);
            chk("write sel", s_sel, 4'b0011);
            chk("write data", s_wdat, 32'h12345678);
            chk("write m0_ack", m0_ack, 0);
            @(negedge clk);
        end
        tick();
        s_ack = 1;
        @(negedge clk);
        chk("write m1_ack", m1_ack, 1);
        chk("write m0_ack at ack", m0_ack, 0);
        tick();
        s_ack = 0;
        set_m(1, 0, 0, 0, 0, 0);
        tick();

        // ---- tie arbitration, starting from reset ----
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        for (int r = 0; r < 4; r++) begin
            set_m(0, 1, 0, 32'h10 + r, 0, 4'hF);
            set_m(1, 1, 0, 32'h20 + r, 0, 4'hF);
            wait_any(4, win);
            chk("tie winner", win, exp_seq[r]);
            tick();
            s_ack = 1; s_rdat = 32'hA0 + r;
            tick();
            s_ack = 0; s_rdat = 0;
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        tick();
        tick();

        // ---- watchdog timeout with m1 pending ----
        set_m(0, 1, 0, 32'h300, 0, 4'hF);
        wait_any(4, win);
        chk("timeout winner", win, 0);
        g = cyc_cnt;
        tick();
        set_m(1, 1, 0, 32'h400, 0, 4'hF);
        seen = 0;
        e = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m0_err === 1'b1) begin
                seen = 1;
                e = cyc_cnt;
                break;
            end
        end
        chk("err seen", seen, 1);
        chk("err at grant+T", e - g, T);
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("after err release", grant, 2'b00);
        chk("err one cycle", m0_err, 0);
        @(negedge clk);
        chk("after err idle", grant, 2'b00);
        @(negedge clk);
        chk("pending m1 granted", grant, 2'b10);
        finish_xfer(32'h55);

        // ---- m0 abandons cycle, slave acks late ----
        set_m(0, 1, 0, 32'h500, 0, 4'hF);
        wait_any(4, win);
        tick();
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        s_ack = 1; s_rdat = 32'hCAFEF00D;
        @(negedge clk);
        chk("late ack m0", m0_ack, 0);
        chk("late ack m1", m1_ack, 0);
        chk("late ack idle grant", grant, 2'b00);
        chk("late ack s_cyc", s_cyc, 0);
        tick();
        s_ack = 0; s_rdat = 0;
        tick();

        // ---- async reset during GNT1 ----
        set_m(1, 1, 0, 32'h600, 0, 4'hF);
        wait_any(4, win);
        chk("rst test winner", win, 1);
        tick();
        #1 rst_n = 0;
        #1;
        chk("async rst s_cyc", s_cyc, 0);
        chk("async rst grant", grant, 2'b00);
        set_m(1, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1;
        tick();
        set_m(0, 1, 0, 32'h700, 0, 4'hF);
        set_m(1, 1, 0, 32'h800, 0, 4'hF);
        wait_any(4, win);
        chk("first tie after reset", win, 0);
        finish_xfer(32'h77);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
